// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-cache backing memory.
package dmem_pkg;
    localparam int BLOCK_BITS  = 128;
    localparam int OFFSET_BITS = 4;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {OP_READ, OP_WRITE} op_t;
endpackage

// File: rtl/dmem_block_array.sv
// Block storage: synchronous write, combinational read, cleared by reset.
module dmem_block_array
    import dmem_pkg::*;
#(
    parameter int INDEX_BITS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] addr_i,
    input  logic [BLOCK_BITS-1:0] wdata_i,
    output logic [BLOCK_BITS-1:0] rdata_o
);
    localparam int DEPTH = 1 << INDEX_BITS;

    logic [BLOCK_BITS-1:0] mem_q [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/data_memory_block.sv
// Fixed-latency block memory behind the data cache, busywait handshake.
//   state | meaning
//   IDLE  | waiting; a read/write request is accepted on the next edge
//   BUSY  | counting down the access latency; access performed at count 0
//   DONE  | result presented with busywait low; requests ignored
module data_memory_block
    import dmem_pkg::*;
#(
    parameter int LATENCY    = 5,
    parameter int INDEX_BITS = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [31:0]           mem_address,
    input  logic [BLOCK_BITS-1:0] mem_writedata,
    output logic [BLOCK_BITS-1:0] mem_readdata,
    output logic                  mem_busywait
);
    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [INDEX_BITS-1:0]   idx_q, idx_d;
    op_t                     op_q, op_d;
    logic [BLOCK_BITS-1:0]   wdata_q, wdata_d;
    logic [BLOCK_BITS-1:0]   rdata_q, rdata_d;
    logic [BLOCK_BITS-1:0]   arr_rdata;
    logic                    req;
    logic                    complete;
    logic                    arr_we;
    logic                    unused_addr_bits;

    assign req      = mem_read | mem_write;
    assign complete = (state_q == BUSY) && (cnt_q == 4'd0);
    assign arr_we   = complete && (op_q == OP_WRITE);
    assign unused_addr_bits = ^{mem_address[31:INDEX_BITS+OFFSET_BITS],
                                mem_address[OFFSET_BITS-1:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            op_q    <= OP_READ;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = BUSY;
                    cnt_d   = 4'(LATENCY - 1);
                    idx_d   = mem_address[INDEX_BITS+OFFSET_BITS-1:OFFSET_BITS];
                    // a simultaneous read+write resolves to the write
                    op_d    = mem_write ? OP_WRITE : OP_READ;
                    wdata_d = mem_writedata;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    if (op_q == OP_READ) begin
                        rdata_d = arr_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    dmem_block_array #(
        .INDEX_BITS(INDEX_BITS)
    ) u_array (
        .clock   (clock),
        .reset   (reset),
        .we_i    (arr_we),
        .addr_i  (idx_q),
        .wdata_i (wdata_q),
        .rdata_o (arr_rdata)
    );

    assign mem_readdata = rdata_q;
    assign mem_busywait = !reset && (((state_q == IDLE) && req) || (state_q == BUSY));
endmodule

// File: tb/tb_data_memory_block.sv
// Scoreboarded random/directed bench for data_memory_block.
module tb_data_memory_block;
    localparam int LAT   = 5;
    localparam int IB    = 8;
    localparam int DEPTH = 1 << IB;

    logic         clock = 1'b0;
    logic         reset;
    logic         mem_read, mem_write;
    logic [31:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    data_memory_block #(.LATENCY(LAT), .INDEX_BITS(IB)) dut (
        .clock         (clock),
        .reset         (reset),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [127:0] rdata;
        int           busy_len;
    } exp_t;

    exp_t         exp_q[$];
    logic [127:0] model_mem [DEPTH];
    logic [127:0] model_last;
    int checks = 0;
    int errors = 0;
    int issued = 0;
    int completions = 0;

    // Behavioural model: a block is addressed by byte address / 16, modulo DEPTH.
    function automatic int blk(input logic [31:0] a);
        return int'((a / 16) % DEPTH);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_last = '0;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: one completion per high-to-low transition of busywait.
    int  run = 0;
    bit  prev_busy = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            run = 0;
            prev_busy = 1'b0;
        end else begin
            if (mem_busywait) begin
                run++;
            end else if (prev_busy) begin
                completions++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_completion: got completion with empty queue, expected none");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("readdata", mem_readdata, e.rdata);
                    if (run != e.busy_len) begin
                        errors++;
                        $display("FAIL busy_len: got %0d expected %0d", run, e.busy_len);
                    end
                end
                run = 0;
            end
            prev_busy = mem_busywait;
        end
    end

    // Called #1 after a rising edge; returns #1 after the edge that leaves DONE.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] addr,
                             input logic [127:0] data, input bit keep, input bit scramble);
        exp_t e;
        int   n;
        if (wr) begin
            model_mem[blk(addr)] = data;
        end else begin
            model_last = model_mem[blk(addr)];
        end
        e.rdata    = model_last;
        e.busy_len = LAT + 1;
        exp_q.push_back(e);
        issued++;
        mem_read      = rd;
        mem_write     = wr;
        mem_address   = addr;
        mem_writedata = data;
        n = 0;
        @(negedge clock);
        while (mem_busywait && n < 100) begin
            @(posedge clock);
            #1;
            n++;
            if (scramble) begin
                mem_address   = $urandom;
                mem_writedata = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clock);
        end
        if (n >= 100) begin
            errors++;
            $display("FAIL access_timeout: got busywait still high after %0d cycles, expected low", n);
        end
        @(posedge clock);
        #1;
        if (!keep) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1;
        mem_read = 1'b0;
        mem_write = 1'b0;
        mem_address = '0;
        mem_writedata = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("reset_busy", {127'b0, mem_busywait}, 128'd0);
        check("reset_rdata", mem_readdata, 128'd0);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // read after reset returns zero; busywait rises in the same cycle
        mem_read = 1'b1;
        mem_address = 32'h0000_0040;
        #1;
        check("busy_immediate", {127'b0, mem_busywait}, 128'd1);
        mem_read = 1'b0;
        #1;
        check("busy_follows_req", {127'b0, mem_busywait}, 128'd0);
        do_access(1, 0, 32'h0000_0040, '0, 0, 0);

        // offset bits ignored
        do_access(0, 1, 32'h0000_0050, 128'h44444444_33333333_22222222_11111111, 0, 0);
        do_access(1, 0, 32'h0000_005C, '0, 0, 0);

        // index wrap-around
        do_access(0, 1, 32'h0000_1010, 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678, 0, 0);
        do_access(1, 0, 32'h0000_0010, '0, 0, 0);

        // request held past completion: exactly one extra access
        do_access(1, 0, 32'h0000_0050, '0, 1, 0);
        do_access(1, 0, 32'h0000_0050, '0, 0, 0);

        // read+write together: write wins, readdata unchanged
        do_access(1, 1, 32'h0000_0020, {16{8'hAA}}, 0, 0);
        check("rw_rdata_hold", mem_readdata, 128'h44444444_33333333_22222222_11111111);
        do_access(1, 0, 32'h0000_0020, '0, 0, 0);

        // randomized traffic with inputs scrambled during service
        for (int i = 0; i < 40; i++) begin
            logic [31:0]  a;
            logic [127:0] d;
            int           op;
            a  = {$urandom_range(0, 3) == 0 ? $urandom : 32'h0, 4'h0} ^ {20'h0, 4'($urandom), 4'($urandom), 4'($urandom)};
            d  = {$urandom, $urandom, $urandom, $urandom};
            op = $urandom_range(0, 4);
            do_access(op == 0 || op == 1 || op == 4, op == 2 || op == 3 || op == 4,
                      a, d, 0, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clock);
                #1;
            end
        end

        // reset during a write: abandoned, array cleared
        mem_write = 1'b1;
        mem_address = 32'h0000_0030;
        mem_writedata = {4{32'h5A5A_A5A5}};
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check("midreset_busy", {127'b0, mem_busywait}, 128'd0);
        check("midreset_rdata", mem_readdata, 128'd0);
        @(posedge clock);
        #1;
        mem_write = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("post_reset_idle", {127'b0, mem_busywait}, 128'd0);
        do_access(1, 0, 32'h0000_0030, '0, 0, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
        check("queue_drained", 128'(exp_q.size()), 128'd0);
        check("access_count", 128'(completions), 128'(issued));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_memory_block.md
Name: data_memory_block

Overview:
- Main-memory responder at the far end of the data cache's memory-side interface.
- Serves whole 128-bit cache-block reads (fills) and block writes (dirty write-backs) with a fixed, parameterised access latency.
- Uses a busywait handshake: the cache raises mem_read or mem_write and stalls while mem_busywait is high.
- Sits between the data cache and the (simulated) backing store of the pipeline CPU.

Parameters:
- LATENCY, 5: access cycles from request acceptance to completion; legal range is 1 to 15.
- INDEX_BITS, 8: block-address bits, giving DEPTH = 2^INDEX_BITS blocks of 16 bytes each.

Ports:
- clock  input  1  system clock, rising-edge.
- reset  input  1  reset, asynchronous, active-high.
- mem_read  input  1  block read request from the cache; held until busywait falls.
- mem_write  input  1  block write request from the cache; held until busywait falls.
- mem_address  input  32  byte address; bits [3:0] ignored (block-aligned).
- mem_writedata  input  128  block to write; word 0 in [31:0].
- mem_readdata  output  128  block returned by the last completed read.
- mem_busywait  output  1  high while a request is pending or in service.

Behaviour:
- Block index = mem_address[INDEX_BITS+3:4]. Address bits above this are ignored, so addresses wrap modulo DEPTH.
- FSM states:
  - IDLE -> BUSY: on a rising edge with mem_read or mem_write high. Capture the index, the op, and mem_writedata; load the counter with LATENCY-1.
  - BUSY: the counter decrements each edge. At the edge where the counter is 0, perform the access and go to DONE.
  - DONE -> IDLE: unconditionally after one cycle. Requests seen in DONE are not accepted, so a request still high from the just-finished access is never serviced twice.
- mem_busywait is combinational: high when (IDLE and (mem_read or mem_write)) or BUSY; low in DONE.
  - Consequence: busywait rises in the same cycle the request appears.
  - Busywait falls after the LATENCY-th rising edge following the accepting edge.
- Read completion: mem_readdata is loaded from the array at the completion edge. It is valid while busywait is low in DONE and holds its value until the next read completes. Writes never change mem_readdata.
- Write completion: the array entry is written at the completion edge with the data captured at acceptance. Later changes on mem_writedata are ignored.
- mem_read and mem_write both high at acceptance: the write is performed and the read is dropped; mem_readdata is unchanged.
- Input changes during BUSY (address, data, op, or request deassertion) are ignored; the captured access always completes.
- LATENCY=1: accept at edge N, complete at edge N+1, DONE for the following cycle.
- Reset values, applied asynchronously at any time including mid-access:
  - state = IDLE, counter = 0, mem_readdata = 0, all array blocks = 0.
  - An in-flight access is abandoned with no array write.
  - mem_busywait follows the inputs once reset is released.

Decomposition:
- Shared package (dmem_pkg):
  - Constants BLOCK_BITS=128 and OFFSET_BITS=4.
  - FSM state type {IDLE, BUSY, DONE}.
  - Operation type {OP_READ, OP_WRITE}.
- One sub-module: dmem_block_array.
  - Synchronous write, combinational read, DEPTH x 128 bits, asynchronous clear on reset.
  - The top level holds the FSM, latency counter, capture registers and readdata register.

Test Plan:
- Reset then read, address 0x0000_0040, LATENCY=5 -> busywait high immediately; low after the 5th edge following acceptance; mem_readdata = 0.
- Write 0x0000_0050 with data 0x44444444_33333333_22222222_11111111, then read 0x0000_005C -> read returns the same 128-bit value (offset bits ignored); each access holds busywait for exactly 5 edges.
- Write to 0x0000_1010 then read 0x0000_0010 with INDEX_BITS=8 -> the same block is returned (wrap-around).
- Requester keeps mem_read high for 2 extra cycles after busywait falls -> exactly one DONE cycle with busywait low, then a new access is accepted; verify the access count via a state monitor.
- mem_read and mem_write both high with data 0xAA..AA at 0x20 -> the array is written and mem_readdata is unchanged; a later read of 0x20 returns 0xAA..AA.
- Assert reset at the 3rd edge of a write to 0x30 -> busywait low during reset, FSM back in IDLE; a later read of 0x30 returns 0.
